// File: rtl/spiker_stream_unwrap.sv
// rtl/spiker_stream_unwrap.sv - streams captured spike vector to the core per timestep
// and OR-accumulates the returned result beats.
module spiker_stream_unwrap #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  parameter int CHUNK    = 64,
  parameter int STEP_W   = 8,
  localparam int N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH,
  localparam int N_BEATS = (N_SPIKES + CHUNK - 1) / CHUNK,
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [STEP_W-1:0]        n_steps_i,
  input  logic [N_WORDS*WIDTH-1:0] spikes_i,
  output logic                     spk_valid_o,
  input  logic                     spk_ready_i,
  output logic [CHUNK-1:0]         spk_data_o,
  output logic                     spk_last_o,
  input  logic                     res_valid_i,
  input  logic [CHUNK-1:0]         res_data_i,
  output logic                     res_ready_o,
  output logic [N_SPIKES-1:0]      result_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int IN_W  = N_WORDS * WIDTH;
  localparam int PAD_W = N_BEATS * CHUNK;
  localparam logic [IN_W-1:0] IN_MASK = {IN_W{1'b1}} >> (IN_W - N_SPIKES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t              state;
  state_t              state_n;
  logic [PAD_W-1:0]    shadow;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   steps_m1;
  logic [N_SPIKES-1:0] res_next;
  logic                last_beat;
  logic                last_step;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign last_step = (step_cnt == steps_m1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start_i) state_n = SEND;
      SEND: if (spk_ready_i && last_beat) state_n = RECV;
      RECV: if (res_valid_i && last_beat) state_n = last_step ? DONE : SEND;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign spk_valid_o = (state == SEND);
  assign spk_last_o  = (state == SEND) && last_beat;
  assign res_ready_o = (state == RECV);
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign spk_data_o  = (state == SEND) ? shadow[int'(beat_cnt)*CHUNK +: CHUNK] : '0;

  // Only result bits belonging to the current beat take the OR; padding above N_SPIKES never exists.
  always_comb begin
    res_next = result_o;
    for (int p = 0; p < N_SPIKES; p++) begin
      if ((p / CHUNK) == int'(beat_cnt)) res_next[p] = result_o[p] | res_data_i[p % CHUNK];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow   <= '0;
      beat_cnt <= '0;
      step_cnt <= '0;
      steps_m1 <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            shadow   <= PAD_W'(spikes_i & IN_MASK);
            steps_m1 <= (n_steps_i == '0) ? '0 : n_steps_i - STEP_W'(1);
            result_o <= '0;
            beat_cnt <= '0;
            step_cnt <= '0;
          end
        end
        SEND: begin
          if (spk_ready_i) beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
        RECV: begin
          if (res_valid_i) begin
            result_o <= res_next;
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
            if (last_beat && !last_step) step_cnt <= step_cnt + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
